jump_ctrl: RTL

//  Sequences conditional jumps through the 4-way flag mux. Holds the ALU flag register
//  (ZF/NF/CF/OF), waits for in-flight ALU flags, and drives the mux select.

---
 rtl/jump_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/jump_ctrl.sv
// jump_ctrl: sequences conditional jumps through an external 4-way flag mux.
// Holds the ALU flag register, waits for in-flight ALU flags, drives the mux
// select, resolves the returned flag bit and issues a one-cycle PC load.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   flags_vld, zf/nf/cf/of_in    ALU flag update strobe and flag values
//   alu_busy                     ALU op in flight, flags not yet final
//   jmp_req, jmp_cond,           jump request (held until accepted), condition
//   jmp_always, jmp_target       {invert, index}, unconditional flag, destination
//   mux_bit                      flag bit returned by the external mux
//   flag_vec, sel                registered flags {of,cf,nf,zf} and mux select
//   jmp_busy                     request in progress
//   pc_load, pc_target           PC load pulse and captured target
//   jmp_done, jmp_taken, jmp_err completion pulse with result / timeout status
module jump_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flags_vld,
    input  logic              zf_in,
    input  logic              nf_in,
    input  logic              cf_in,
    input  logic              of_in,
    input  logic              alu_busy,
    input  logic              jmp_req,
    input  logic [2:0]        jmp_cond,
    input  logic              jmp_always,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              mux_bit,
    output logic [3:0]        flag_vec,
    output logic [1:0]        sel,
    output logic              jmp_busy,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              jmp_done,
    output logic              jmp_taken,
    output logic              jmp_err
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, WAIT_FLAGS, SELECT, RESOLVE, ABORT} state_t;

    state_t        state;
    logic [2:0]    cond;
    logic          always_q;
    logic [CW-1:0] cnt;
    logic          taken;

    assign jmp_busy = state != IDLE;
    assign taken    = always_q | (mux_bit ^ cond[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flag_vec  <= '0;
            sel       <= '0;
            pc_target <= '0;
            cond      <= '0;
            always_q  <= 1'b0;
            cnt       <= '0;
            pc_load   <= 1'b0;
            jmp_done  <= 1'b0;
            jmp_taken <= 1'b0;
            jmp_err   <= 1'b0;
        end else begin
            pc_load   <= 1'b0;
            jmp_done  <= 1'b0;
            jmp_taken <= 1'b0;
            jmp_err   <= 1'b0;
            if (flags_vld)
                flag_vec <= {of_in, cf_in, nf_in, zf_in};
            case (state)
                IDLE: if (jmp_req) begin
                    cond      <= jmp_cond;
                    always_q  <= jmp_always;
                    pc_target <= jmp_target;
                    cnt       <= '0;
                    // flags arriving in the accept cycle are latched now, so no wait is needed
                    state     <= (alu_busy && !flags_vld) ? WAIT_FLAGS : SELECT;
                end
                WAIT_FLAGS: begin
                    cnt <= cnt + CW'(1);
                    if (flags_vld)
                        state <= SELECT;
                    else if (cnt == CW'(WAIT_MAX))
                        state <= ABORT;
                end
                SELECT: begin
                    sel   <= cond[1:0];
                    state <= RESOLVE;
                end
                RESOLVE: begin
                    jmp_done  <= 1'b1;
                    jmp_taken <= taken;
                    pc_load   <= taken;
                    state     <= IDLE;
                end
                ABORT: begin
                    jmp_done <= 1'b1;
                    jmp_err  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
